nw_traceback: RTL

Sequential Needleman-Wunsch aligner that turns two strings into an alignment. It fills the score matrix one cell per cycle, storing a 2-bit direction per cell, then walks back from the corner and streams one edit operation per handshake. It complements the combinational grid scorer: same recurrence, weights and tie-breaks, so its `score` must equal the grid's for any input. It sits behind the scorer in the benchmark harness when the alignment itself is needed.

---
 rtl/nw_pkg.sv | 20 ++
 rtl/nw_cell_step.sv | 45 ++++
 rtl/nw_traceback.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/nw_pkg.sv
// Shared encodings for the Needleman-Wunsch traceback aligner: edit ops,
// stored cell directions and the controller state type.
package nw_pkg;

  localparam logic [1:0] MATCH_OP    = 2'd0;
  localparam logic [1:0] MISMATCH_OP = 2'd1;
  localparam logic [1:0] DEL_OP      = 2'd2;
  localparam logic [1:0] INS_OP      = 2'd3;

  localparam logic [1:0] DIR_DIAG = 2'd0;
  localparam logic [1:0] DIR_UP   = 2'd1;
  localparam logic [1:0] DIR_LEFT = 2'd2;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StTrace
  } nw_state_e;

endpackage

// File: rtl/nw_cell_step.sv
// One Needleman-Wunsch cell: picks the best of top/left/diagonal candidates and
// reports which one won, using the same tie-break as the combinational grid scorer.
module nw_cell_step
  import nw_pkg::*;
#(
  parameter int unsigned CWIDTH   = 2,
  parameter int unsigned SWIDTH   = 16,
  parameter int          MATCH    = 1,
  parameter int          INDEL    = -1,
  parameter int          MISMATCH = -1
) (
  input  logic signed [SWIDTH-1:0] top_i,
  input  logic signed [SWIDTH-1:0] left_i,
  input  logic signed [SWIDTH-1:0] diag_i,
  input  logic        [CWIDTH-1:0] c1_i,
  input  logic        [CWIDTH-1:0] c2_i,
  output logic signed [SWIDTH-1:0] h_o,
  output logic        [1:0]        dir_o
);

  localparam logic signed [SWIDTH-1:0] IndelW = SWIDTH'(INDEL);
  localparam logic signed [SWIDTH-1:0] MatchW = SWIDTH'(MATCH);
  localparam logic signed [SWIDTH-1:0] MismW  = SWIDTH'(MISMATCH);

  logic signed [SWIDTH-1:0] t, l, d;

  always_comb begin
    t = top_i + IndelW;
    l = left_i + IndelW;
    d = diag_i + ((c1_i == c2_i) ? MatchW : MismW);
    h_o   = d;
    dir_o = DIR_DIAG;
    // Top beats left on a tie; the survivor beats diagonal on a tie.
    if (t >= l) begin
      if (t >= d) begin
        h_o   = t;
        dir_o = DIR_UP;
      end
    end else if (l >= d) begin
      h_o   = l;
      dir_o = DIR_LEFT;
    end
  end

endmodule

// File: rtl/nw_traceback.sv
// Sequential Needleman-Wunsch aligner: fills a direction matrix one cell per cycle,
// then streams the edit script from the bottom-right corner back to the origin.
module nw_traceback
  import nw_pkg::*;
#(
  parameter int unsigned LENGTH   = 10,
  parameter int unsigned CWIDTH   = 2,
  parameter int unsigned SWIDTH   = 16,
  parameter int          MATCH    = 1,
  parameter int          INDEL    = -1,
  parameter int          MISMATCH = -1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [LENGTH*CWIDTH-1:0]   s1,
  input  logic [LENGTH*CWIDTH-1:0]   s2,
  output logic                       busy,
  output logic signed [SWIDTH-1:0]   score,
  output logic                       score_valid,
  output logic [1:0]                 op,
  output logic                       op_valid,
  input  logic                       op_ready,
  output logic                       op_last
);

  localparam int unsigned CntW  = $clog2(LENGTH + 1);
  localparam int unsigned AddrW = (LENGTH > 1) ? $clog2(LENGTH * LENGTH) : 1;
  localparam logic [CntW-1:0] LenCnt = CntW'(LENGTH);
  localparam logic [CntW-1:0] One    = CntW'(1);
  localparam logic signed [SWIDTH-1:0] IndelW = SWIDTH'(INDEL);

  nw_state_e state_q, state_d;
  logic [LENGTH*CWIDTH-1:0] s1_q, s2_q;
  logic [CntW-1:0] i_q, i_d, j_q, j_d;
  logic signed [SWIDTH-1:0] row_q [0:LENGTH];
  logic signed [SWIDTH-1:0] diag_q, edge_q, score_q;
  logic score_valid_q;
  logic [1:0] dir_q [0:LENGTH*LENGTH-1];

  logic [CWIDTH-1:0] c1, c2;
  logic signed [SWIDTH-1:0] top_in, left_in, diag_in, cell_h;
  logic [1:0] cell_dir, dir_rd;
  logic [AddrW-1:0] cell_idx;
  logic accept, fill_last;
  logic [1:0] tr_op;
  logic [CntW-1:0] tr_i, tr_j;
  logic tr_last;

  // Character k (1-based) of a packed string; index 0 is the gap side and yields 0.
  function automatic logic [CWIDTH-1:0] char_at(input logic [LENGTH*CWIDTH-1:0] s,
                                                input logic [CntW-1:0] k);
    logic [CWIDTH-1:0] c;
    c = '0;
    if (k != '0 && int'(k) <= int'(LENGTH)) c = s[CWIDTH*(int'(LENGTH) - int'(k)) +: CWIDTH];
    return c;
  endfunction

  assign c1 = char_at(s1_q, i_q);
  assign c2 = char_at(s2_q, j_q);

  // row_q is updated in place, so row_q[j-1] already holds H(i,j-1); column 0 comes
  // from edge_q, which tracks H(i-1,0).
  always_comb begin
    top_in = row_q[j_q];
    if (j_q <= One) begin
      diag_in = edge_q;
      left_in = edge_q + IndelW;
    end else begin
      diag_in = diag_q;
      left_in = row_q[j_q - One];
    end
    cell_idx = '0;
    if (i_q != '0 && j_q != '0) begin
      cell_idx = AddrW'((int'(i_q) - 1) * int'(LENGTH) + int'(j_q) - 1);
    end
  end

  nw_cell_step #(
    .CWIDTH  (CWIDTH),
    .SWIDTH  (SWIDTH),
    .MATCH   (MATCH),
    .INDEL   (INDEL),
    .MISMATCH(MISMATCH)
  ) u_step (
    .top_i (top_in),
    .left_i(left_in),
    .diag_i(diag_in),
    .c1_i  (c1),
    .c2_i  (c2),
    .h_o   (cell_h),
    .dir_o (cell_dir)
  );

  assign dir_rd = dir_q[cell_idx];

  always_comb begin
    tr_op = INS_OP;
    tr_i  = i_q;
    tr_j  = j_q;
    if (i_q == '0) begin
      tr_j = j_q - One;
    end else if (j_q == '0) begin
      tr_op = DEL_OP;
      tr_i  = i_q - One;
    end else begin
      case (dir_rd)
        DIR_UP: begin
          tr_op = DEL_OP;
          tr_i  = i_q - One;
        end
        DIR_LEFT: begin
          tr_j = j_q - One;
        end
        default: begin
          tr_op = (c1 == c2) ? MATCH_OP : MISMATCH_OP;
          tr_i  = i_q - One;
          tr_j  = j_q - One;
        end
      endcase
    end
    tr_last = (tr_i == '0) && (tr_j == '0);
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    accept    = 1'b0;
    fill_last = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          accept  = 1'b1;
          state_d = StFill;
          i_d     = One;
          j_d     = One;
        end
      end
      StFill: begin
        if (j_q == LenCnt) begin
          j_d = One;
          i_d = i_q + One;
          if (i_q == LenCnt) begin
            fill_last = 1'b1;
            state_d   = StTrace;
            i_d       = LenCnt;
            j_d       = LenCnt;
          end
        end else begin
          j_d = j_q + One;
        end
      end
      StTrace: begin
        if (op_ready) begin
          i_d = tr_i;
          j_d = tr_j;
          if (tr_last) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      s1_q          <= '0;
      s2_q          <= '0;
      i_q           <= '0;
      j_q           <= '0;
      diag_q        <= '0;
      edge_q        <= '0;
      score_q       <= '0;
      score_valid_q <= 1'b0;
      for (int k = 0; k <= int'(LENGTH); k++) row_q[k] <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      if (accept) begin
        s1_q          <= s1;
        s2_q          <= s2;
        score_valid_q <= 1'b0;
        diag_q        <= '0;
        edge_q        <= '0;
        for (int k = 0; k <= int'(LENGTH); k++) row_q[k] <= SWIDTH'(k * INDEL);
      end
      if (state_q == StFill) begin
        row_q[j_q] <= cell_h;
        diag_q     <= top_in;
        if (j_q == LenCnt) edge_q <= edge_q + IndelW;
      end
      if (fill_last) begin
        score_q       <= cell_h;
        score_valid_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StFill) dir_q[cell_idx] <= cell_dir;
  end

  assign busy        = (state_q != StIdle);
  assign op_valid    = (state_q == StTrace);
  assign op          = op_valid ? tr_op : 2'b00;
  assign op_last     = op_valid & tr_last;
  assign score       = score_q;
  assign score_valid = score_valid_q;

endmodule
